// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  // Upper bound on requesters; the round-robin search is sized for this many.
  localparam int unsigned MaxReq  = 8;
  localparam int unsigned MaxIdxW = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StWait = 2'd2
  } arb_state_e;

  // Ten bit times per frame plus a little slack before a frame is declared lost.
  function automatic int unsigned timeout_cycles(input int unsigned clocks_per_bit);
    return 10 * clocks_per_bit + 8;
  endfunction

  localparam int unsigned DefaultClocksPerBit  = 3;
  localparam int unsigned DefaultTimeoutCycles = 10 * DefaultClocksPerBit + 8;

  typedef struct packed {
    logic                 any;
    logic [MaxIdxW-1:0]   idx;
  } rr_result_t;

  // First set bit of req at or above ptr, wrapping modulo num_req.
  function automatic rr_result_t rr_search(input logic [MaxReq-1:0]  req,
                                           input logic [MaxIdxW-1:0] ptr,
                                           input int unsigned        num_req);
    rr_result_t  res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      cand = (32'(ptr) + k) % num_req;
      if (k < num_req && !res.any && req[cand[MaxIdxW-1:0]]) begin
        res.any = 1'b1;
        res.idx = cand[MaxIdxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: request vector and start pointer in,
// winning index and any-request flag out.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic [MaxReq-1:0] req_ext;
  rr_result_t        res;
  logic              unused_idx_bits;

  // Widen the request vector to the helper's fixed size and search.
  always_comb begin
    req_ext              = '0;
    req_ext[NumReq-1:0]  = req_i;
    res                  = rr_search(req_ext, MaxIdxW'(ptr_i), NumReq);
  end

  assign idx_o           = res.idx[IdxW-1:0];
  assign any_o           = res.any;
  // Upper index bits are always zero for small NumReq.
  assign unused_idx_bits = ^res.idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional packet lock (define UART_ARB_PACKET_LOCK_EN): a byte accepted with
// req_last low keeps the grant on that requester until its last byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned CLOCKS_PER_BIT = DefaultClocksPerBit,
  parameter  int unsigned TIMEOUT_CYCLES = timeout_cycles(CLOCKS_PER_BIT),
  localparam int unsigned IdxW           = $clog2(NUM_REQ),
  localparam int unsigned CntW           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
`ifdef UART_ARB_PACKET_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_last,
  output logic                 locked,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_send,
  output logic [7:0]           uart_byte,
  input  logic                 uart_done,
  output logic [IdxW-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic [7:0]           byte_q, byte_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 send_q, send_d;
  logic                 tout_q, tout_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
`ifdef UART_ARB_PACKET_LOCK_EN
  logic                 lock_q, lock_d;
`endif

  logic [NUM_REQ-1:0]   pick_req;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;
  logic [7:0]           pick_byte;
  logic [IdxW-1:0]      rr_ptr_inc;

  // While locked only the locked requester may win the search.
`ifdef UART_ARB_PACKET_LOCK_EN
  assign pick_req = lock_q ? (req_valid & (NUM_REQ'(1) << grant_q)) : req_valid;
`else
  assign pick_req = req_valid;
`endif

  rr_pick #(
    .NumReq (NUM_REQ)
  ) u_rr_pick (
    .req_i (pick_req),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Select the winning requester's byte and the pointer just past it.
  always_comb begin
    pick_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IdxW'(i)) begin
        pick_byte = req_byte[8*i +: 8];
      end
    end
    rr_ptr_inc = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  // Next-state logic: grant in IDLE, one-cycle send, then wait for done or timeout.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    byte_d   = byte_q;
    ready_d  = '0;
    send_d   = 1'b0;
    tout_d   = 1'b0;
    cnt_d    = cnt_q;
`ifdef UART_ARB_PACKET_LOCK_EN
    lock_d   = lock_q;
`endif

    case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d  = StSend;
          grant_d  = pick_idx;
          byte_d   = pick_byte;
          ready_d  = NUM_REQ'(1) << pick_idx;
`ifdef UART_ARB_PACKET_LOCK_EN
          // A locked grant does not move the round-robin pointer.
          if (!lock_q) begin
            rr_ptr_d = rr_ptr_inc;
          end
          lock_d   = ~req_last[pick_idx];
`else
          rr_ptr_d = rr_ptr_inc;
`endif
        end
      end
      StSend: begin
        state_d = StWait;
        send_d  = 1'b1;
        cnt_d   = '0;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // done takes priority over a timeout landing on the same cycle.
        if (uart_done) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StIdle;
          tout_d  = 1'b1;
`ifdef UART_ARB_PACKET_LOCK_EN
          lock_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, aborting any frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      byte_q   <= '0;
      ready_q  <= '0;
      send_q   <= 1'b0;
      tout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef UART_ARB_PACKET_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      byte_q   <= byte_d;
      ready_q  <= ready_d;
      send_q   <= send_d;
      tout_q   <= tout_d;
      cnt_q    <= cnt_d;
`ifdef UART_ARB_PACKET_LOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

  assign req_ready   = ready_q;
  assign uart_send   = send_q;
  assign uart_byte   = byte_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = tout_q;
`ifdef UART_ARB_PACKET_LOCK_EN
  assign locked      = lock_q;
`endif

  // Handshake invariants.
  a_ready_onehot: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(req_ready));
  a_send_single: assert property (@(posedge clock) disable iff (!reset_n)
    uart_send |=> !uart_send);
  a_tout_idle: assert property (@(posedge clock) disable iff (!reset_n)
    timeout_err |-> !busy);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter (NUM_REQ=4, CLOCKS_PER_BIT=3).
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq = 4;
  localparam int unsigned MaxLen = 8;

  logic                 clock;
  logic                 reset_n;
  logic [NumReq-1:0]    req_valid;
  logic [8*NumReq-1:0]  req_byte;
  logic [NumReq-1:0]    req_ready;
  logic                 uart_send;
  logic [7:0]           uart_byte;
  logic                 uart_done;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 timeout_err;
`ifdef UART_ARB_PACKET_LOCK_EN
  logic [NumReq-1:0]    req_last;
  logic                 locked;
`endif

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .CLOCKS_PER_BIT (3)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_byte    (req_byte),
`ifdef UART_ARB_PACKET_LOCK_EN
    .req_last    (req_last),
    .locked      (locked),
`endif
    .req_ready   (req_ready),
    .uart_send   (uart_send),
    .uart_byte   (uart_byte),
    .uart_done   (uart_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors;
  int miscompares;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-requester byte streams fed by the driver.
  logic [7:0] src_data [NumReq][MaxLen];
  logic       src_last [NumReq][MaxLen];
  int         src_len  [NumReq];
  int         src_pos  [NumReq];

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: next round-robin start and lock owner (-1 = none).
  int model_ptr;
  int model_lock;

  // Fill the streams and predict the full grant order: every requester with
  // bytes left stays valid, so each grant is the first non-empty stream from
  // the model pointer (or the lock owner while locked).
  task automatic load_batch(input int l0, input int l1, input int l2, input int l3,
                            input bit lock_pattern);
    int lens [NumReq];
    int left [NumReq];
    int total;
    int pick;
    int cand;
    lens  = '{l0, l1, l2, l3};
    total = 0;
    for (int i = 0; i < NumReq; i++) begin
      for (int j = 0; j < lens[i]; j++) begin
        src_data[i][j] = 8'($urandom);
        if (j == lens[i] - 1)  src_last[i][j] = 1'b1;
        else if (lock_pattern) src_last[i][j] = 1'b0;
        else                   src_last[i][j] = 1'($urandom_range(0, 1));
      end
      left[i]    = lens[i];
      total     += lens[i];
      src_pos[i] = 0;
      src_len[i] = lens[i];
    end
    while (total > 0) begin
      pick = -1;
`ifdef UART_ARB_PACKET_LOCK_EN
      if (model_lock >= 0) pick = model_lock;
`endif
      for (int k = 0; k < NumReq; k++) begin
        cand = (model_ptr + k) % NumReq;
        if (pick < 0 && left[cand] > 0) pick = cand;
      end
      exp_q.push_back('{id: 2'(pick), data: src_data[pick][lens[pick] - left[pick]],
                        last: src_last[pick][lens[pick] - left[pick]]});
`ifdef UART_ARB_PACKET_LOCK_EN
      if (model_lock < 0) model_ptr = (pick + 1) % NumReq;
      model_lock = src_last[pick][lens[pick] - left[pick]] ? -1 : pick;
`else
      model_ptr = (pick + 1) % NumReq;
`endif
      left[pick]--;
      total--;
    end
  endtask

  // Requester driver: hold valid while a stream has bytes, advance on accept.
  initial begin
    req_valid = '0;
    req_byte  = '0;
`ifdef UART_ARB_PACKET_LOCK_EN
    req_last  = '0;
`endif
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NumReq; i++) begin
        if (req_ready[i] && src_pos[i] < src_len[i]) src_pos[i]++;
        if (src_pos[i] < src_len[i]) begin
          req_valid[i]        = 1'b1;
          req_byte[8*i +: 8]  = src_data[i][src_pos[i]];
`ifdef UART_ARB_PACKET_LOCK_EN
          req_last[i]         = src_last[i][src_pos[i]];
`endif
        end else begin
          req_valid[i]        = 1'b0;
          req_byte[8*i +: 8]  = 8'h00;
`ifdef UART_ARB_PACKET_LOCK_EN
          req_last[i]         = 1'b0;
`endif
        end
      end
    end
  end

  // UART model: done pulses a fixed or random number of cycles after send.
  int done_cnt;
  int done_delay;
  bit rand_delay;
  bit silent;
  bit done_inject;

  initial begin
    uart_done = 1'b0;
    done_cnt  = 0;
    forever begin
      @(posedge clock);
      #1;
      uart_done = done_inject;
      if (!reset_n) begin
        done_cnt = 0;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) uart_done = 1'b1;
      end
      if (reset_n && uart_send && !silent) begin
        done_cnt = rand_delay ? int'($urandom_range(1, 30)) : done_delay;
      end
    end
  end

  // Monitor: compare accepts and sends against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && req_ready != '0) begin
        if (exp_q.size() == 0) begin
          check("ready_unexpected", 32'(req_ready), 0);
        end else begin
          check("req_ready", 32'(req_ready), 32'(1) << exp_q[0].id);
          check("accept_grant", 32'(grant_id), 32'(exp_q[0].id));
`ifdef UART_ARB_PACKET_LOCK_EN
          check("locked", 32'(locked), 32'(!exp_q[0].last));
`endif
        end
      end
      if (reset_n && uart_send) begin
        if (exp_q.size() == 0) begin
          check("send_unexpected", 32'(uart_send), 0);
        end else begin
          e = exp_q.pop_front();
          check("uart_byte", 32'(uart_byte), 32'(e.data));
          check("send_grant", 32'(grant_id), 32'(e.id));
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 0);
    check({name, "_idle"}, 32'(busy), 0);
    @(negedge clock);
  endtask

  // Returns at the negedge of the cycle in which uart_send is high.
  task automatic wait_send(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (uart_send !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(uart_send), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_uart_send"}, 32'(uart_send), 0);
    check({tag, "_uart_byte"}, 32'(uart_byte), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
`ifdef UART_ARB_PACKET_LOCK_EN
    check({tag, "_locked"}, 32'(locked), 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_ptr   = 0;
    model_lock  = -1;
    done_delay  = 30;
    rand_delay  = 1'b0;
    silent      = 1'b0;
    done_inject = 1'b0;
    reset_n     = 1'b0;

    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Single request from requester 0 with a known byte.
    load_batch(1, 0, 0, 0, 1'b0);
    src_data[0][0] = 8'hB9;
    exp_q.delete();
    exp_q.push_back('{id: 2'd0, data: 8'hB9, last: 1'b1});
    @(negedge clock);
    check("single_no_ready_yet", 32'(req_ready), 0);
    @(negedge clock);
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_no_send_yet", 32'(uart_send), 0);
    @(negedge clock);
    check("single_ready_pulse", 32'(req_ready), 0);
    check("single_send", 32'(uart_send), 1);
    check("single_byte", 32'(uart_byte), 32'hB9);
    check("single_busy", 32'(busy), 1);
    @(negedge clock);
    check("single_send_pulse", 32'(uart_send), 0);
    for (int k = 0; k < 28; k++) begin
      @(negedge clock);
      check("single_byte_held", 32'(uart_byte), 32'hB9);
    end
    @(negedge clock);
    check("single_busy_at_done", 32'(busy), 1);
    @(negedge clock);
    check("single_idle_after_done", 32'(busy), 0);
    drain("single", 50);

    // All four requesters continuously valid.
    load_batch(2, 2, 2, 2, 1'b0);
    drain("all_valid", 600);

    // Random stream lengths and random done latency.
    rand_delay = 1'b1;
    for (int b = 0; b < 12; b++) begin
      load_batch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      drain("random", 800);
    end
    rand_delay = 1'b0;

    // Stray done while idle.
    done_inject = 1'b1;
    @(negedge clock);
    done_inject = 1'b0;
    check("stray_busy", 32'(busy), 0);
    @(negedge clock);
    check("stray_busy_after", 32'(busy), 0);
    check("stray_no_timeout", 32'(timeout_err), 0);
    check("stray_no_send", 32'(uart_send), 0);

    // Silent UART: each frame times out, then the next requester is served.
    silent = 1'b1;
    load_batch(0, 0, 1, 1, 1'b0);
    wait_send("timeout_first_send");
    for (int k = 1; k <= 38; k++) begin
      @(negedge clock);
      if (k == 37) begin
        check("timeout_not_early", 32'(timeout_err), 0);
        check("timeout_still_busy", 32'(busy), 1);
      end
      if (k == 38) begin
        check("timeout_pulse", 32'(timeout_err), 1);
        check("timeout_idle", 32'(busy), 0);
      end
    end
    @(negedge clock);
    check("timeout_single_pulse", 32'(timeout_err), 0);
    drain("timeout", 200);
    silent = 1'b0;

    // done on the last allowed WAIT cycle wins over the timeout.
    done_delay = 37;
    load_batch(1, 0, 0, 0, 1'b0);
    wait_send("coincide_send");
    repeat (37) @(negedge clock);
    check("coincide_busy", 32'(busy), 1);
    @(negedge clock);
    check("coincide_no_timeout", 32'(timeout_err), 0);
    check("coincide_idle", 32'(busy), 0);
    drain("coincide", 50);
    done_delay = 30;

    // Reset in the middle of WAIT.
    load_batch(0, 0, 1, 0, 1'b0);
    wait_send("reset_send");
    repeat (5) @(negedge clock);
    #2;
    reset_n    = 1'b0;
    model_ptr  = 0;
    model_lock = -1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    load_batch(0, 1, 0, 1, 1'b0);
    drain("post_reset_ptr", 200);
    load_batch(0, 0, 0, 1, 1'b0);
    drain("post_reset_req3", 100);

`ifdef UART_ARB_PACKET_LOCK_EN
    // Three-byte packet from requester 0 must not be interleaved with requester 1.
    load_batch(3, 1, 0, 0, 1'b1);
    drain("lock", 400);
    check("lock_released", 32'(locked), 0);
    for (int b = 0; b < 6; b++) begin
      rand_delay = 1'b1;
      load_batch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      drain("lock_random", 800);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart` transmitter among NUM_REQ byte producers, e.g. telemetry, debug console and motor status.
- Round-robin arbitration picks a requester and latches its byte.
- Sequences the uart's `send`/`byte_to_send`/`done` interface and returns a per-requester accept handshake.
- Sits between producer logic and the single `uart` instance driving the TX pin.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- CLOCKS_PER_BIT, 3, must equal the attached uart's clocks_per_bit; used only for the timeout.
- TIMEOUT_CYCLES, 10*CLOCKS_PER_BIT+8, WAIT-state cycles allowed before abort.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  bit i: requester i has a byte pending.
- req_byte  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-cycle accept pulse; the byte was taken this cycle.
- uart_send  out  1  to uart `send`.
- uart_byte  out  8  to uart `byte_to_send`.
- uart_done  in  1  from uart `done`; one-cycle pulse at end of stop bit.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset values (async, immediate): state=IDLE, rr_ptr=0, req_ready=0, uart_send=0, uart_byte=0, grant_id=0, busy=0, timeout_err=0, wait counter=0.
- Reset mid-frame drops uart_send at once. The byte is lost and no req_ready is reissued.
- States: IDLE -> SEND -> WAIT -> IDLE.
- IDLE:
  - If any req_valid, select the first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - Same edge: latch req_byte[i] into uart_byte, set grant_id=i, pulse req_ready[i], set rr_ptr=(i+1) mod NUM_REQ, go to SEND.
  - If no req_valid, stay in IDLE.
- Accept latency: req_valid high in IDLE -> req_ready pulse in the following cycle, registered. The requester may drop or change req_byte after the pulse.
- SEND: uart_send=1 for exactly one cycle. Go to WAIT and clear the counter.
- WAIT:
  - uart_send=0; uart_byte is held stable.
  - Counter increments every cycle.
  - On uart_done=1: go to IDLE.
  - Else if counter==TIMEOUT_CYCLES-1: pulse timeout_err, go to IDLE.
  - If uart_done and timeout coincide, uart_done wins and no error is raised.
- uart_done is ignored in IDLE and SEND. A stray pulse has no effect.
- Back-to-back throughput: IDLE (grant) -> SEND -> WAIT...done -> IDLE. Minimum gap is 2 cycles between uart_done and the next uart_send.
- Only one req_ready bit is high in any cycle.
- req_valid bits for non-granted requesters are never acknowledged until granted.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: UART_ARB_PACKET_LOCK_EN.
- With the macro:
  - Extra input port req_last (NUM_REQ bits), sampled with the accepted byte.
  - If req_last[i]=0 at acceptance, the arbiter locks to requester i. The next IDLE grants only i, waiting indefinitely for req_valid[i], and rr_ptr is not advanced.
  - Lock clears when a byte is accepted with req_last[i]=1, on timeout_err, or on reset.
  - Output `locked` (1 bit) reflects the lock state; reset value 0.
- Without the macro: no req_last or locked ports, and every byte is re-arbitrated.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum (IDLE, SEND, WAIT), 2 bits;
  - localparam for the default timeout formula;
  - helper function for the round-robin index search.
- One natural sub-module: rr_pick. It is combinational: req vector + pointer -> grant index + any_valid.
- The FSM and counter stay in the top module.

Test Plan (NUM_REQ=4, CLOCKS_PER_BIT=3, uart model with done after 30 cycles):
- Single request: req_valid=0001, req_byte[7:0]=8'hB9 -> req_ready=0001 for 1 cycle, uart_send 1 cycle later with uart_byte=8'hB9, busy until done+1.
- All four valid continuously -> grant order 0,1,2,3,0; each req_ready exactly once per frame.
- Silent uart (done never pulses) -> timeout_err pulses 38 cycles after WAIT entry, state IDLE, next requester served.
- reset_n low mid-WAIT -> all outputs 0 asynchronously, rr_ptr=0; after release req_valid=1000 -> grant_id=3.
- uart_done pulse in IDLE, plus done coinciding with the timeout cycle -> no state change and no timeout_err, respectively.
- With UART_ARB_PACKET_LOCK_EN: req0 sends 3 bytes with req_last=0,0,1 while req1 is valid -> req0's three bytes are consecutive, then req1 is granted; locked is high between the first and third bytes.
